// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the divide sequencer: RV32M op encodings, FSM states,
// operand constants and the small sign-handling helpers used by the controller.
package div_seq_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  // funct3[1:0] of the M-extension divide group
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_FIXUP,
    S_RESP
  } state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return !op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

  // abs(INT_MIN) wraps back to INT_MIN, which is the right unsigned magnitude
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? -x : x;
  endfunction

  function automatic logic [XLEN-1:0] fix_sign(input div_op_e op, input logic neg_q,
                                               input logic neg_r, input logic [XLEN-1:0] q,
                                               input logic [XLEN-1:0] r);
    if (op_is_rem(op)) return neg_r ? -r : r;
    return neg_q ? -q : q;
  endfunction

endpackage

// File: rtl/div_seq_ctrl_divu.sv
// Unsigned 32-bit restoring divider: one quotient bit per clock, 32 cycles
// after the start edge. A new start always restarts it, even mid-operation.
module div_seq_ctrl_divu
  import div_seq_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            dbz
);

  logic [5:0]      cnt;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN:0]   trial;

  // The partial remainder stays below the divisor, so 33 bits hold the trial
  always_comb begin
    trial = {remainder, quotient[XLEN-1]} - {1'b0, divisor_q};
  end

  // No reset here: the controller only trusts valid after it has issued a start.
  always_ff @(posedge clk) begin
    if (start) begin
      remainder <= '0;
      quotient  <= dividend;
      divisor_q <= divisor;
      cnt       <= 6'(XLEN);
      busy      <= 1'b1;
      valid     <= 1'b0;
    end else if (busy) begin
      if (!trial[XLEN]) begin
        remainder <= trial[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], 1'b1};
      end else begin
        remainder <= {remainder[XLEN-2:0], quotient[XLEN-1]};
        quotient  <= {quotient[XLEN-2:0], 1'b0};
      end
      cnt <= cnt - 1'b1;
      if (cnt == 6'd1) begin
        busy  <= 1'b0;
        valid <= 1'b1;
      end
    end
  end

  assign dbz = (divisor_q == '0);

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer between execute and the shared unsigned divider: signed/unsigned
// RV32M divide and remainder with zero/overflow fast paths and a last-result cache.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int TAG_W    = 5,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  state_e           state;
  div_op_e          op_q;
  logic [TAG_W-1:0] tag_q;
  logic             neg_q_q, neg_r_q;
  logic [XLEN-1:0]  rs1_q, rs2_q, abs_a_q, abs_b_q;

  logic             cache_vld, c_signed;
  logic [XLEN-1:0]  c_rs1, c_rs2, c_q, c_r;

  logic             div_start, div_busy, div_valid, div_dbz_unused;
  logic [XLEN-1:0]  div_q, div_r;

  div_op_e          req_op;
  logic             req_signed, req_neg_q, req_neg_r;
  logic             cache_hit, fast_hit;
  logic [XLEN-1:0]  fast_result;

  assign req_op     = div_op_e'(op_i);
  assign req_signed = op_is_signed(req_op);
  assign req_neg_q  = req_signed && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
  assign req_neg_r  = req_signed && rs1_i[XLEN-1];

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    fast_hit    = 1'b1;
    fast_result = '0;
    cache_hit   = CACHE_EN && cache_vld && (rs1_i == c_rs1) && (rs2_i == c_rs2)
                  && (req_signed == c_signed);
    if (rs2_i == '0) begin
      fast_result = op_is_rem(req_op) ? rs1_i : ALL_ONES;
    end else if (req_signed && (rs1_i == INT_MIN) && (rs2_i == ALL_ONES)) begin
      fast_result = op_is_rem(req_op) ? '0 : INT_MIN;
    end else if (cache_hit) begin
      fast_result = fix_sign(req_op, req_neg_q, req_neg_r, c_q, c_r);
    end else begin
      fast_hit = 1'b0;
    end
  end

  assign req_ready_o = (state == S_IDLE) && !flush_i;
  assign div_start   = (state == S_LAUNCH);

  div_seq_ctrl_divu u_divu (
    .clk       (clk_i),
    .start     (div_start),
    .dividend  (abs_a_q),
    .divisor   (abs_b_q),
    .busy      (div_busy),
    .valid     (div_valid),
    .quotient  (div_q),
    .remainder (div_r),
    .dbz       (div_dbz_unused)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      rsp_valid_o <= 1'b0;
      result_o    <= '0;
      tag_o       <= '0;
      cache_vld   <= 1'b0;
      op_q        <= OP_DIV;
      tag_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      abs_a_q     <= '0;
      abs_b_q     <= '0;
    end else if (flush_i) begin
      // A late divider valid is harmless: only RUN looks at it
      state       <= S_IDLE;
      rsp_valid_o <= 1'b0;
      cache_vld   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            op_q    <= req_op;
            tag_q   <= tag_i;
            neg_q_q <= req_neg_q;
            neg_r_q <= req_neg_r;
            rs1_q   <= rs1_i;
            rs2_q   <= rs2_i;
            abs_a_q <= abs_val(rs1_i, req_signed);
            abs_b_q <= abs_val(rs2_i, req_signed);
            if (fast_hit) begin
              result_o    <= fast_result;
              tag_o       <= tag_i;
              rsp_valid_o <= 1'b1;
              state       <= S_RESP;
            end else begin
              state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: state <= S_RUN;
        S_RUN: begin
          if (div_valid && !div_busy) state <= S_FIXUP;
        end
        S_FIXUP: begin
          result_o    <= fix_sign(op_q, neg_q_q, neg_r_q, div_q, div_r);
          tag_o       <= tag_q;
          rsp_valid_o <= 1'b1;
          cache_vld   <= CACHE_EN;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: cache payload has no reset; cache_vld alone decides whether it is used.
  always_ff @(posedge clk_i) begin
    if (state == S_FIXUP && !flush_i) begin
      c_rs1    <= rs1_q;
      c_rs2    <= rs2_q;
      c_signed <= op_is_signed(op_q);
      c_q      <= div_q;
      c_r      <= div_r;
    end
  end

endmodule
